// File: rtl/masked_scan_pipe_pkg.sv
// masked_pipe_pkg: share packing and width helpers for the masked scan pipeline
package masked_pipe_pkg;
  function automatic int share_slice(int s, int width);
    return s * width;
  endfunction
  function automatic int occ_width(int depth);
    return depth < 2 ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/masked_scan_pipe_if.sv
// masked_scan_pipe_if: control, share data and status bundle of the masked scan pipeline
interface masked_scan_pipe_if import masked_pipe_pkg::*; #(
  parameter int SHARES = 2,
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) ();
  logic sel;
  logic en;
  logic flush;
  logic in_valid;
  logic [SHARES*WIDTH-1:0] D0;
  logic [SHARES*WIDTH-1:0] D1;
  logic [SHARES*WIDTH-1:0] Q;
  logic out_valid;
  logic [occ_width(DEPTH)-1:0] occupancy;
  modport master (output sel, en, flush, in_valid, D0, D1, input Q, out_valid, occupancy);
  modport slave (input sel, en, flush, in_valid, D0, D1, output Q, out_valid, occupancy);
endinterface

// File: rtl/masked_scan_pipe_scan_dff_en.sv
// scan_dff_en: one-share scan-mux register with enable and synchronous clear
module scan_dff_en #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = clr_i ? '0 : en_i ? (sel_i ? d1_i : d0_i) : q_q;
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  end
  assign q_o = q_q;
endmodule

// File: rtl/masked_scan_pipe.sv
// masked_scan_pipe: per-share scan-mux feeding a DEPTH-stage pipeline with stall, flush and valid tracking
module masked_scan_pipe import masked_pipe_pkg::*; #(
  parameter int SHARES = 2,
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input logic clk,
  input logic rst_n,
  masked_scan_pipe_if.slave bus
);
  localparam int OCC_W = occ_width(DEPTH);
  logic [WIDTH-1:0] st [DEPTH][SHARES];
  logic [DEPTH-1:0] v_q, v_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  // each share owns its own register chain; only sel and control are common
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    for (genvar s = 0; s < SHARES; s++) begin : g_share
      if (i == 0) begin : g_mux
        scan_dff_en #(.WIDTH(WIDTH)) u_reg (
          .clk(clk), .rst_n(rst_n), .clr_i(bus.flush), .en_i(bus.en), .sel_i(bus.sel),
          .d0_i(bus.D0[share_slice(s, WIDTH) +: WIDTH]),
          .d1_i(bus.D1[share_slice(s, WIDTH) +: WIDTH]),
          .q_o(st[i][s])
        );
      end else begin : g_pipe
        scan_dff_en #(.WIDTH(WIDTH)) u_reg (
          .clk(clk), .rst_n(rst_n), .clr_i(bus.flush), .en_i(bus.en), .sel_i(1'b0),
          .d0_i(st[i-1][s]), .d1_i('0), .q_o(st[i][s])
        );
      end
      if (i == DEPTH - 1) begin : g_out
        assign bus.Q[share_slice(s, WIDTH) +: WIDTH] = st[i][s];
      end
    end
  end
  always_comb begin
    v_d = bus.flush ? '0 : bus.en ? DEPTH'({v_q, bus.in_valid}) : v_q;
    occ_d = bus.flush ? '0 : bus.en ? occ_q + OCC_W'(bus.in_valid) - OCC_W'(v_q[DEPTH-1]) : occ_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      occ_q <= '0;
    end else begin
      v_q <= v_d;
      occ_q <= occ_d;
    end
  end
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_masked_scan_pipe.sv
// tb_masked_scan_pipe: directed checks of select, latency, stall, flush, reset and share isolation
module tb_masked_scan_pipe;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  masked_scan_pipe_if #(.SHARES(2), .WIDTH(4), .DEPTH(1)) bus_a ();
  masked_scan_pipe_if #(.SHARES(2), .WIDTH(4), .DEPTH(3)) bus_b ();
  masked_scan_pipe_if #(.SHARES(3), .WIDTH(4), .DEPTH(1)) bus_c ();

  masked_scan_pipe #(.SHARES(2), .WIDTH(4), .DEPTH(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  masked_scan_pipe #(.SHARES(2), .WIDTH(4), .DEPTH(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  masked_scan_pipe #(.SHARES(3), .WIDTH(4), .DEPTH(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] x;
    bus_a.sel = 1; bus_a.en = 1; bus_a.flush = 0; bus_a.in_valid = 1;
    bus_b.sel = 1; bus_b.en = 1; bus_b.flush = 0; bus_b.in_valid = 1;
    bus_c.sel = 1; bus_c.en = 1; bus_c.flush = 0; bus_c.in_valid = 1;
    bus_a.D0 = 8'($urandom); bus_a.D1 = 8'($urandom);
    bus_b.D0 = 8'($urandom); bus_b.D1 = 8'($urandom);
    bus_c.D0 = 12'($urandom); bus_c.D1 = 12'($urandom);
    // reset held for two edges with live inputs
    tick();
    tick();
    chk("rst_a_q", bus_a.Q, 0);
    chk("rst_a_ov", bus_a.out_valid, 0);
    chk("rst_a_occ", bus_a.occupancy, 0);
    chk("rst_b_q", bus_b.Q, 0);
    chk("rst_b_ov", bus_b.out_valid, 0);
    chk("rst_b_occ", bus_b.occupancy, 0);
    chk("rst_c_q", bus_c.Q, 0);
    rst_n = 1;
    bus_a.en = 0; bus_b.en = 0; bus_c.en = 0;
    tick();
    // select path, DEPTH=1
    bus_a.D0 = 8'hA5; bus_a.D1 = 8'h3C; bus_a.sel = 0; bus_a.en = 1; bus_a.in_valid = 1;
    tick();
    chk("sel0_q", bus_a.Q, 8'hA5);
    chk("sel0_ov", bus_a.out_valid, 1);
    chk("sel0_occ", bus_a.occupancy, 1);
    bus_a.sel = 1;
    tick();
    chk("sel1_q", bus_a.Q, 8'h3C);
    chk("sel1_occ", bus_a.occupancy, 1);
    bus_a.en = 0; bus_a.sel = 0; bus_a.in_valid = 0;
    tick();
    chk("hold_a_q", bus_a.Q, 8'h3C);
    chk("hold_a_ov", bus_a.out_valid, 1);
    // latency and stall, DEPTH=3
    bus_b.sel = 0; bus_b.en = 1; bus_b.in_valid = 1; bus_b.D1 = 8'hEE;
    bus_b.D0 = 8'd1; tick();
    bus_b.D0 = 8'd2; tick();
    chk("lat_early_ov", bus_b.out_valid, 0);
    bus_b.D0 = 8'd3; tick();
    chk("lat_q", bus_b.Q, 1);
    chk("lat_ov", bus_b.out_valid, 1);
    chk("lat_occ", bus_b.occupancy, 3);
    bus_b.en = 0; bus_b.D0 = 8'd9; bus_b.sel = 1;
    tick();
    tick();
    chk("stall_q", bus_b.Q, 1);
    chk("stall_occ", bus_b.occupancy, 3);
    bus_b.en = 1; bus_b.in_valid = 0; bus_b.sel = 0; bus_b.D0 = 8'd7;
    tick();
    chk("drain1_q", bus_b.Q, 2);
    chk("drain1_occ", bus_b.occupancy, 2);
    tick();
    chk("drain2_q", bus_b.Q, 3);
    chk("drain2_occ", bus_b.occupancy, 1);
    tick();
    chk("drain3_q", bus_b.Q, 7);
    chk("drain3_ov", bus_b.out_valid, 0);
    chk("drain3_occ", bus_b.occupancy, 0);
    // flush beats en
    bus_b.in_valid = 1;
    bus_b.D0 = 8'd4; tick();
    bus_b.D0 = 8'd5; tick();
    bus_b.D0 = 8'd6; tick();
    chk("fill_occ", bus_b.occupancy, 3);
    chk("fill_q", bus_b.Q, 4);
    bus_b.flush = 1; bus_b.D0 = 8'hFF;
    tick();
    chk("flush_q", bus_b.Q, 0);
    chk("flush_ov", bus_b.out_valid, 0);
    chk("flush_occ", bus_b.occupancy, 0);
    bus_b.flush = 0; bus_b.in_valid = 0; bus_b.D0 = 8'h00;
    tick();
    tick();
    chk("flush_nocap_q", bus_b.Q, 0);
    chk("flush_nocap_occ", bus_b.occupancy, 0);
    // reset mid-stream
    bus_b.in_valid = 1;
    bus_b.D0 = 8'h08; tick();
    bus_b.D0 = 8'h09; tick();
    chk("pre_rst_occ", bus_b.occupancy, 2);
    rst_n = 0;
    tick();
    chk("mid_rst_q", bus_b.Q, 0);
    chk("mid_rst_ov", bus_b.out_valid, 0);
    chk("mid_rst_occ", bus_b.occupancy, 0);
    rst_n = 1;
    bus_b.D0 = 8'h0A; tick();
    bus_b.D0 = 8'h0B; tick();
    chk("refill_early_ov", bus_b.out_valid, 0);
    bus_b.D0 = 8'h0C; tick();
    chk("refill_q", bus_b.Q, 8'h0A);
    chk("refill_ov", bus_b.out_valid, 1);
    chk("refill_occ", bus_b.occupancy, 3);
    bus_b.en = 0;
    // share isolation, SHARES=3
    bus_c.sel = 1; bus_c.en = 1; bus_c.in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      x = 4'(i * 7 + 3);
      bus_c.D1 = {4'h5, x, 4'h3};
      bus_c.D0 = 12'($urandom);
      tick();
      chk("iso_s0", 32'(bus_c.Q[3:0]), 4'h3);
      chk("iso_s1", 32'(bus_c.Q[7:4]), 32'(x));
      chk("iso_s2", 32'(bus_c.Q[11:8]), 4'h5);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
